// File: rtl/bats_feed_arbiter_if.sv
`timescale 1ns/1ps
// bats_feed_arbiter_if
//   Bundles the per-source feed bus and the parser-facing UDP payload bus.
//   Source k occupies lane k of the packed arrays, so src_bytes lays out as
//   bits [64k+63:64k] when viewed flat.
//   master : arbiter view (samples sources and parser ready, drives
//            src_ready and the out_ip_* parser inputs)
//   slave  : environment view (sources + parser)
//   NUM_SRC must match the arbiter's NUM_SRC.
interface bats_feed_arbiter_if #(parameter int NUM_SRC = 2);
  logic [NUM_SRC-1:0][63:0] src_bytes;
  logic [NUM_SRC-1:0][7:0]  src_byte_enables;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_ready;
  logic [63:0]              out_ip_bytes;
  logic [7:0]               out_ip_byte_enables;
  logic                     out_ip_data_valid;
  logic                     in_ip_ready_for_udp_input;
  logic                     out_ip_reset;

  modport master (
    input  src_bytes, src_byte_enables, src_valid, src_last,
    input  in_ip_ready_for_udp_input,
    output src_ready, out_ip_bytes, out_ip_byte_enables, out_ip_data_valid,
    output out_ip_reset
  );

  modport slave (
    output src_bytes, src_byte_enables, src_valid, src_last,
    output in_ip_ready_for_udp_input,
    input  src_ready, out_ip_bytes, out_ip_byte_enables, out_ip_data_valid,
    input  out_ip_reset
  );
endinterface

// File: rtl/bats_feed_arbiter.sv
`timescale 1ns/1ps
// bats_feed_arbiter
//   Shares the BATS parser's single UDP payload input between NUM_SRC feed
//   sources. Round-robin at packet granularity, 2-entry FIFO toward the
//   parser, stalled-packet timeout with drain and parser code reset pulse.
// Ports
//   Clk40      : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : bats_feed_arbiter_if.master (source beats, parser bus)
//   grant_id   : currently or last granted source
//   busy       : FSM not in IDLE
//   pkt_count  : (BATS_FEED_ARB_STATS_EN) completed packets per source
//   abort_count: (BATS_FEED_ARB_STATS_EN) timeouts, saturating
// Optional feature macro: BATS_FEED_ARB_STATS_EN
module bats_feed_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RST_CYC     = 4
) (
  input  logic                 Clk40,
  input  logic                 reset_n,
  bats_feed_arbiter_if.master  bus,
  output logic [2:0]           grant_id,
  output logic                 busy
`ifdef BATS_FEED_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] pkt_count,
  output logic [15:0]           abort_count
`endif
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IW = $clog2(TIMEOUT_CYC);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PASS, FLUSH, RST} state_e;
  typedef struct packed {
    logic [63:0] bytes;
    logic [7:0]  be;
  } beat_t;

  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d, ptr_q, ptr_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            ip_rst_q, ip_rst_d;
  beat_t [1:0]     fifo_q, fifo_d;   // [0] is the head
  logic [1:0]      cnt_q, cnt_d;

  logic [NUM_SRC-1:0] ready;
  logic [SW-1:0]   gsel, cand;
  logic            pop, can_take, accept, g_valid, g_last, push, abort;
  logic            found, wr_idx;
  logic [2:0]      pick;
  int              j_c;
  beat_t           g_beat;

  function automatic logic [2:0] nxt_src(input logic [2:0] g);
    nxt_src = (g == 3'(NUM_SRC - 1)) ? 3'd0 : g + 3'd1;
  endfunction

  assign gsel     = grant_q[SW-1:0];
  assign pop      = (cnt_q != 2'd0) & bus.in_ip_ready_for_udp_input;
  // Full FIFO still takes a beat when the head leaves on the same edge.
  assign can_take = (cnt_q < 2'd2) | pop;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_rdy
    assign ready[k] = (grant_q == 3'(k)) &
                      (((state_q == PASS) & can_take) | (state_q == FLUSH));
  end

  assign bus.src_ready = ready;
  assign g_valid = bus.src_valid[gsel];
  assign g_last  = bus.src_last[gsel];
  assign g_beat  = '{bytes: bus.src_bytes[gsel], be: bus.src_byte_enables[gsel]};
  assign accept  = |(bus.src_valid & ready);

  // Circular search from ptr_q for the first requester.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    j_c   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j_c  = (int'(ptr_q) + i) % NUM_SRC;
      cand = SW'(j_c);
      if (!found && bus.src_valid[cand]) begin
        found = 1'b1;
        pick  = 3'(j_c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    idle_d  = idle_q;
    rcnt_d  = rcnt_q;
    push    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        idle_d  = '0;
        state_d = PASS;
      end
      PASS: begin
        if (accept) begin
          push   = 1'b1;
          idle_d = '0;
          if (g_last) begin
            ptr_d   = nxt_src(grant_q);
            state_d = IDLE;
          end
        end else if (!g_valid) begin
          // Parser backpressure holds the counter; only source silence counts.
          if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
            abort   = 1'b1;
            state_d = FLUSH;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      FLUSH: if (accept && g_last) begin
        rcnt_d  = '0;
        state_d = RST;
      end
      RST: begin
        if (rcnt_q == RW'(RST_CYC - 1)) begin
          ptr_d   = nxt_src(grant_q);
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered decode so the parser reset never glitches.
    ip_rst_d = (state_d == RST);
  end

  // Shift FIFO: head at [0]; the write slot accounts for a same-edge pop.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    wr_idx = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & ~pop);
    if (abort) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) fifo_d[wr_idx] = g_beat;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      idle_q   <= '0;
      rcnt_q   <= '0;
      ip_rst_q <= 1'b0;
      fifo_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      idle_q   <= idle_d;
      rcnt_q   <= rcnt_d;
      ip_rst_q <= ip_rst_d;
      fifo_q   <= fifo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_ip_bytes        = fifo_q[0].bytes;
  assign bus.out_ip_byte_enables = fifo_q[0].be;
  assign bus.out_ip_data_valid   = (cnt_q != 2'd0);
  assign bus.out_ip_reset        = ip_rst_q;
  assign grant_id                = grant_q;
  assign busy                    = (state_q != IDLE);

`ifdef BATS_FEED_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0] pkt_q, pkt_d;
  logic [15:0]              abort_q, abort_d;

  always_comb begin
    pkt_d   = pkt_q;
    abort_d = abort_q;
    if ((state_q == PASS) && accept && g_last) pkt_d[gsel] = pkt_q[gsel] + 32'd1;
    if (abort && (abort_q != 16'hFFFF)) abort_d = abort_q + 16'd1;
  end

  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q   <= '0;
      abort_q <= '0;
    end else begin
      pkt_q   <= pkt_d;
      abort_q <= abort_d;
    end
  end

  assign pkt_count   = pkt_q;
  assign abort_count = abort_q;
`endif

endmodule
